mult_sched: RTL and testbench

- Round-robin scheduler that shares one seq_mult instance (N-bit x N-bit, sequential) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready channels and sequences the multiplier through its reset/start protocol.
- Waits for the multiplier's data_rdy, then returns the product with the requester ID on one shared response channel.
- Sits between crypto/field-arithmetic clients and the multiplier; includes a watchdog against a hung multiplier.

---
 rtl/mult_sched_pkg.sv | 28 ++
 rtl/mult_sched_if.sv | 36 +++
 rtl/mult_sched_arb.sv | 47 ++++
 rtl/mult_sched.sv | 136 +++++++++++++
 tb/tb_mult_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg
// Shared types and sizing helpers for the multiplier scheduler.
//   state_t     : scheduler FSM states (2-bit encoding)
//   id_width()  : bit width of a requester index for a given requester count
//   wd_width()  : bit width of a watchdog able to count up to a given timeout
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int TIMEOUT_DFLT = 1024;

    // A single requester still needs a 1-bit index field.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int WD_W_DFLT = wd_width(TIMEOUT_DFLT);

endpackage

// File: rtl/mult_sched_if.sv
// mult_sched_if
// Request/response channels between the clients and the scheduler.
//   req_valid/req_ready : per-requester handshake, req_ready is a one-hot pulse
//   req_a/req_b         : operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_id/rsp_prod/rsp_err : requester index, 2*N-bit product, timeout flag
// Modports: master = client side, slave = scheduler side.
interface mult_sched_if
    import mult_sched_pkg::*;
#(
    parameter int N    = 256,
    parameter int NREQ = 4
);
    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [2*N-1:0]    rsp_prod;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

endinterface

// File: rtl/mult_sched_arb.sv
// rr_arbiter
// Combinational round-robin pick. Searches upward from last+1, wrapping
// modulo NREQ, and returns the first requester with req set. Holds no state;
// the pointer lives in the caller.
//   req       : request vector
//   last      : index of the previous winner
//   en        : when low no grant is produced
//   grant     : one-hot winner
//   grant_idx : binary index of the winner
//   grant_any : a winner exists
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        idx       = '0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = int'(last) + k;
                if (cand >= NREQ) cand = cand - NREQ;
                idx = ID_W'(cand);
                if (!grant_any && req[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// mult_sched
// Round-robin scheduler sharing one sequential N x N multiplier between NREQ
// requesters. Accepts an operand pair, restarts the multiplier with it, waits
// for data_rdy (or a watchdog timeout) and returns the product tagged with the
// requester index on a single response channel.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : request/response channels (slave side)
//   mult_rst_n  : active-low restart of the multiplier
//   mult_a/b    : operands held stable for the whole operation
//   mult_prod   : multiplier product
//   mult_rdy    : multiplier data ready
//   busy        : scheduler is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grant and operand capture happen here
// LOAD  | one cycle with mult_rst_n low, watchdog cleared
// RUN   | multiplier running; waiting for mult_rdy or watchdog expiry
// RESP  | response presented until rsp_ready
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int N       = 256,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic           clk,
    input  logic           rst,
    mult_sched_if.slave    bus,
    output logic           mult_rst_n,
    output logic [N-1:0]   mult_a,
    output logic [N-1:0]   mult_b,
    input  logic [2*N-1:0] mult_prod,
    input  logic           mult_rdy,
    output logic           busy
);

    localparam int              ID_W     = id_width(NREQ);
    localparam int              WD_W     = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);

    state_t          state;
    logic [ID_W-1:0] last;
    logic [WD_W-1:0] wd;
    logic [ID_W-1:0] rsp_id_q;
    logic [2*N-1:0]  rsp_prod_q;
    logic            rsp_err_q;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;

    // Gating with rst keeps req_ready low while reset is held, even though
    // the state register already reads IDLE.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .last      (last),
        .en        ((state == IDLE) && !rst),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = bus.req_a[i*N +: N];
                sel_b = bus.req_b[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= LAST_RST;
            wd         <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        mult_a   <= sel_a;
                        mult_b   <= sel_b;
                        rsp_id_q <= grant_idx;
                        last     <= grant_idx;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // wd == 0 marks the first RUN cycle, where a ready left
                    // over from the previous operation may still be visible.
                    if (mult_rdy && (wd != '0)) begin
                        rsp_prod_q <= mult_prod;
                        rsp_err_q  <= 1'b0;
                        state      <= RESP;
                    end else if (wd == WD_LAST) begin
                        rsp_prod_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Held low throughout reset so the multiplier restarts with the scheduler.
    assign mult_rst_n    = !rst && (state != LOAD);
    assign busy          = (state != IDLE);

    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int N       = 256;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 1024;
    localparam int ID_W    = id_width(NREQ);
    localparam int PW      = 2 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          mult_rst_n;
    logic [N-1:0]  mult_a;
    logic [N-1:0]  mult_b;
    logic [PW-1:0] mult_prod;
    logic          mult_rdy;
    logic          busy;

    mult_sched_if #(.N(N), .NREQ(NREQ)) bus ();

    mult_sched #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mult_rst_n (mult_rst_n),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_prod  (mult_prod),
        .mult_rdy   (mult_rdy),
        .busy       (busy)
    );

    function automatic logic [PW-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    // ---------------- behavioural sequential multiplier ----------------
    // Restarts while rst_n is low, becomes ready after a random latency and
    // keeps ready until the next restart. A stale ready with a junk product is
    // shown in the first cycle after a restart.
    bit            dead   = 1'b0;
    int            lat_min = 1;
    int            lat_max = 12;
    logic          st_rdy;
    logic          stale;
    logic [PW-1:0] st_prod;
    int            cnt;
    int            lat;

    always @(posedge clk) begin
        if (!mult_rst_n) begin
            cnt     <= 0;
            lat     <= $urandom_range(lat_max, lat_min);
            st_rdy  <= 1'b0;
            st_prod <= {16{32'hdeadbeef}};
            stale   <= !dead;
        end else begin
            stale <= 1'b0;
            if (!dead) begin
                if (cnt >= lat) begin
                    st_rdy  <= 1'b1;
                    st_prod <= mul(mult_a, mult_b);
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end
    assign mult_rdy  = st_rdy | stale;
    assign mult_prod = st_prod;

    // ---------------- scoreboard state ----------------
    typedef struct { int id; logic [N-1:0] a; logic [N-1:0] b; } op_t;
    typedef struct { int id; logic [PW-1:0] prod; bit err; } exp_t;

    op_t  pend[$];
    exp_t expq[$];
    int   glog[$];

    logic [N-1:0]    cur_a [NREQ];
    logic [N-1:0]    cur_b [NREQ];
    logic [NREQ-1:0] acc_seen = '0;
    int              rsp_mode = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input bit ok, input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++)
            if (acc_seen[i]) bus.req_valid[i] = 1'b0;
        acc_seen = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i]) begin
                    for (int j = 0; j < pend.size(); j++) begin
                        if (pend[j].id == i) begin
                            cur_a[i] = pend[j].a;
                            cur_b[i] = pend[j].b;
                            bus.req_a[i*N +: N] = pend[j].a;
                            bus.req_b[i*N +: N] = pend[j].b;
                            bus.req_valid[i] = 1'b1;
                            pend.delete(j);
                            break;
                        end
                    end
                end
            end
        end
        case (rsp_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'($urandom_range(1, 0));
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    int              model_last = NREQ - 1;
    bit              rst_prev = 1'b0;
    bit              rsp_prev = 1'b0;
    bit              hs_prev  = 1'b0;
    bit              rdy_prev = 1'b0;
    bit              gnt_prev = 1'b0;
    logic [N-1:0]    ga_prev, gb_prev;
    logic [ID_W-1:0] id_prev;
    logic [PW-1:0]   prod_prev;
    bit              err_prev;
    int              since_load = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        int              g;
        exp_t            e;
        if (!mult_rst_n) since_load = 0;
        else             since_load++;

        if (rst) begin
            if (rst_prev) begin
                chk(bus.req_ready == '0, "rst_req_ready", PW'(bus.req_ready), 0);
                chk(!bus.rsp_valid, "rst_rsp_valid", PW'(bus.rsp_valid), 0);
                chk(bus.rsp_id == '0 && bus.rsp_prod == '0 && !bus.rsp_err, "rst_rsp_fields",
                    bus.rsp_prod | PW'(bus.rsp_id) | PW'(bus.rsp_err), 0);
                chk(mult_a == '0 && mult_b == '0, "rst_mult_ops", PW'(mult_a | mult_b), 0);
                chk(!busy, "rst_busy", PW'(busy), 0);
                chk(!mult_rst_n, "rst_mult_rst_n", PW'(mult_rst_n), 0);
            end
            expq.delete();
            model_last = NREQ - 1;
            acc_seen   = '0;
            rsp_prev   = 1'b0;
            hs_prev    = 1'b0;
            gnt_prev   = 1'b0;
        end else begin
            if (gnt_prev) begin
                chk(!mult_rst_n, "load_after_accept", PW'(mult_rst_n), 0);
                chk(mult_a == ga_prev && mult_b == gb_prev, "load_operands",
                    {mult_a, mult_b}, {ga_prev, gb_prev});
            end
            gnt_prev = 1'b0;

            // Free scheduler: nothing accepted and still unanswered.
            exp_ready = '0;
            g = -1;
            if (expq.size() == 0 && bus.req_valid != '0) begin
                for (int k = 1; k <= NREQ && g < 0; k++)
                    if (bus.req_valid[(model_last + k) % NREQ]) g = (model_last + k) % NREQ;
                exp_ready[g] = 1'b1;
            end
            if (exp_ready != '0 || bus.req_ready != '0)
                chk(bus.req_ready == exp_ready, "req_ready", PW'(bus.req_ready), PW'(exp_ready));
            if (g >= 0) begin
                e.id   = g;
                e.prod = dead ? '0 : mul(cur_a[g], cur_b[g]);
                e.err  = dead;
                expq.push_back(e);
                glog.push_back(g);
                model_last = g;
                gnt_prev   = 1'b1;
                ga_prev    = cur_a[g];
                gb_prev    = cur_b[g];
            end
            acc_seen = bus.req_ready & bus.req_valid;

            if (hs_prev)
                chk(!bus.rsp_valid, "rsp_valid_drop", PW'(bus.rsp_valid), 0);
            if (bus.rsp_valid) begin
                chk(busy, "busy_in_resp", PW'(busy), 1);
                if (rsp_prev && !hs_prev) begin
                    chk(bus.rsp_id == id_prev && bus.rsp_prod == prod_prev && bus.rsp_err == err_prev,
                        "rsp_stable", bus.rsp_prod, prod_prev);
                end
                if (!rsp_prev) begin
                    if (expq.size() == 0) begin
                        chk(1'b0, "unexpected_rsp", PW'(bus.rsp_id), 0);
                    end else if (expq[0].err) begin
                        chk(since_load == TIMEOUT + 1, "timeout_latency", PW'(since_load), PW'(TIMEOUT + 1));
                    end else begin
                        chk(rdy_prev, "rsp_after_rdy", PW'(rdy_prev), 1);
                    end
                end
                if (bus.rsp_ready && expq.size() != 0) begin
                    e = expq.pop_front();
                    chk(int'(bus.rsp_id) == e.id, "rsp_id", PW'(bus.rsp_id), PW'(e.id));
                    chk(bus.rsp_prod == e.prod, "rsp_prod", bus.rsp_prod, e.prod);
                    chk(bus.rsp_err == e.err, "rsp_err", PW'(bus.rsp_err), PW'(e.err));
                end
            end
            hs_prev   = bus.rsp_valid && bus.rsp_ready;
            rsp_prev  = bus.rsp_valid;
            id_prev   = bus.rsp_id;
            prod_prev = bus.rsp_prod;
            err_prev  = bus.rsp_err;
        end
        rdy_prev = mult_rdy;
        rst_prev = rst;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [N-1:0] rnd_op();
        logic [N-1:0] v;
        for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom();
        case ($urandom_range(7, 0))
            0:       v = '0;
            1:       v = '1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        op_t o;
        o.id = id;
        o.a  = a;
        o.b  = b;
        pend.push_back(o);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c = 0;
        while ((pend.size() != 0 || expq.size() != 0 || bus.req_valid != '0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(c < budget, name, PW'(c), PW'(budget));
    endtask

    // Grant order encoded as base-16 digits (index+1) for a single compare.
    function automatic int enc_order(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i] + 1;
        return v;
    endfunction

    task automatic check_order(input string name, input int exp[$]);
        chk(enc_order(glog) == enc_order(exp), name, PW'(enc_order(glog)), PW'(enc_order(exp)));
        glog.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [N-1:0] big_b;
        int c;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            cur_a[i] = '0;
            cur_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single request from requester 0
        push_op(0, N'(5), N'(12));
        wait_drain(500, "drain_single");
        check_order("order_single", '{0});

        // simultaneous requesters 1 and 3
        big_b = '0;
        big_b[N-1 -: 4] = 4'hc;
        push_op(1, '1, N'(2));
        push_op(3, N'(2), big_b);
        wait_drain(500, "drain_pair");
        check_order("order_pair", '{1, 3});

        // saturation with all-ones operands
        for (int i = 0; i < NREQ; i++) push_op(i, '1, '1);
        push_op(0, '1, '1);
        wait_drain(1000, "drain_sat");
        check_order("order_sat", '{0, 1, 2, 3, 0});

        // response back-pressure for 50 cycles
        rsp_mode = 2;
        push_op(2, rnd_op(), rnd_op());
        c = 0;
        while (!bus.rsp_valid && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk(c < 300, "stall_reach_resp", PW'(c), 300);
        push_op(1, rnd_op(), rnd_op());
        repeat (50) @(posedge clk);
        #1 rsp_mode = 0;
        wait_drain(500, "drain_stall");
        check_order("order_stall", '{2, 1});

        // hung multiplier, then a normal operation
        dead = 1'b1;
        push_op(1, rnd_op(), rnd_op());
        wait_drain(TIMEOUT + 200, "drain_timeout");
        dead = 1'b0;
        push_op(1, N'(7), N'(9));
        wait_drain(500, "drain_after_timeout");
        check_order("order_timeout", '{1, 1});

        // reset in the middle of RUN
        lat_min = 40;
        lat_max = 40;
        push_op(2, rnd_op(), rnd_op());
        c = 0;
        while (mult_rst_n && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk(c < 300, "reach_load", PW'(c), 300);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        glog.delete();
        lat_min = 1;
        lat_max = 12;
        push_op(0, rnd_op(), rnd_op());
        push_op(2, rnd_op(), rnd_op());
        wait_drain(500, "drain_after_rst");
        check_order("order_after_rst", '{0, 2});

        // randomized traffic with random response back-pressure
        rsp_mode = 1;
        for (int i = 0; i < 40; i++)
            push_op($urandom_range(NREQ - 1, 0), rnd_op(), rnd_op());
        wait_drain(4000, "drain_random");
        rsp_mode = 0;
        glog.delete();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
